wt_dcache_rd_arb: RTL and testbench
===================================

// Module: wt_dcache_rd_arb
// PURPOSE
//  Shares the single read port of the write-through L1 dcache memory (tag+data arrays) among NumPorts read controllers (load unit, PTW, AMO/store check).
//  Round-robin grant per cycle. The tag phase is tracked one cycle after grant, so each requester's late tag and the returned hit/data are routed to the correct owner.
//  Sits between the per-port read controllers and wt_dcache_mem.
// PARAMETERS
//  NumPorts   3   number of read requesters (>=2)
//  IdxW       DCACHE_CL_IDX_WIDTH   set index width
//  OffW       DCACHE_OFFSET_WIDTH   byte offset width
//  TagW       DCACHE_TAG_WIDTH      tag width
// PORTS
//  clk_i             in   1             clock
//  rst_ni            in   1             reset, asynchronous, active-low
//  clr_i             in   1             synchronous clear (flush), active high
//  port_rd_req_i     in   NumPorts      per-port read request
//  port_rd_tag_only_i in  NumPorts      per-port tag-only lookup
//  port_rd_idx_i     in   NumPorts*IdxW per-port set index (request cycle)
//  port_rd_off_i     in   NumPorts*OffW per-port offset (request cycle)
//  port_rd_tag_i     in   NumPorts*TagW per-port tag (cycle after ack)
//  port_rd_ack_o     out  NumPorts      one-hot accept to port
//  port_rd_vld_o     out  NumPorts      one-hot: mem_rd_data/hit valid for this port this cycle
//  mem_rd_req_o      out  1             read request to memory
//  mem_rd_tag_only_o out  1             muxed tag-only flag
//  mem_rd_idx_o      out  IdxW          muxed index
//  mem_rd_off_o      out  OffW          muxed offset
//  mem_rd_tag_o      out  TagW          tag of port granted in previous cycle
//  mem_rd_ack_i      in   1             memory accepted read (low when a cache-line write owns the arrays)
//  busy_o            out  1             any request pending or tag phase outstanding
// BEHAVIOUR
//  - State: rr_ptr_q (log2 NumPorts), tag_sel_q (one-hot), tag_vld_q. Reset and clr_i: rr_ptr_q=0, tag_sel_q=0, tag_vld_q=0.
//  - Arbitration is combinational. The winner is the first requesting port at or after rr_ptr_q, wrapping modulo NumPorts.
//  - mem_rd_req_o = |port_rd_req_i. idx/off/tag_only are muxed from the winner; all are 0 when there is no request.
//  - port_rd_ack_o[w] = mem_rd_ack_i & request. At most one ack bit is set per cycle.
//  - On an ack: rr_ptr_q <= (w+1) mod NumPorts, tag_sel_q <= onehot(w), tag_vld_q <= 1.
//  - Without an ack: rr_ptr_q holds and tag_vld_q <= 0. A denied requester keeps priority next cycle.
//  - mem_rd_tag_o = port_rd_tag_i selected by tag_sel_q (one-cycle latency from ack). It is 0 when tag_vld_q = 0.
//  - port_rd_vld_o = tag_vld_q ? tag_sel_q : 0. This is the cycle in which mem hit/data belong to that port.
//  - Back-to-back grants are allowed: in one cycle, the tag phase of grant N overlaps the request phase of grant N+1.
//  - A request dropped before ack is legal, and no state changes.
//  - clr_i overrides a simultaneous ack: nothing is recorded and port_rd_vld_o is 0 next cycle. The ack bit is still driven that cycle; the requester handles the kill.
//  - Asynchronous reset mid-transfer: all registers clear and no port_rd_vld_o pulse is produced.
//  - busy_o = mem_rd_req_o | tag_vld_q.
//  - Assertions: port_rd_ack_o and tag_sel_q are onehot0; port_rd_ack_o implies port_rd_req_i.
// CONFIGURATION
//  WT_DCACHE_RD_ARB_STARVE_EN defined:
//   - A per-port wait counter (4 bit) increments each cycle a port requests without an ack. It clears on ack or clr_i and saturates at 15.
//   - A port whose counter reaches 8 overrides the round-robin choice and is granted next. Ties go to the lowest index.
//  Undefined: pure round-robin, no counters.
// TESTING
//  - Reset, then ports 0,1,2 request continuously with mem_rd_ack_i=1 -> acks 0,1,2,0,1,2. port_rd_vld_o follows one cycle later. mem_rd_tag_o carries the matching tag.
//  - Port 1 requests, mem_rd_ack_i=0 for 3 cycles then 1 -> no ack for 3 cycles, ack on cycle 4, rr_ptr stays 1 until then, port_rd_vld_o=3'b010 on cycle 5.
//  - rr_ptr=2, only port 0 requests -> wraps, acks port 0, rr_ptr becomes 1.
//  - Ack to port 2 coincident with clr_i=1 -> port_rd_vld_o=0 next cycle, rr_ptr=0, busy_o=0 if no requests remain.
//  - Port 2 tag_only=1 with idx=0x3F, off=0x8 -> mem outputs idx 0x3F, off 0x8, tag_only 1 in grant cycle; port 2's tag on mem_rd_tag_o the next cycle.
//  - STARVE_EN defined, port 0 requests continuously, ports 1 and 2 are acked alternately by forcing mem_rd_ack_i pattern -> port 0 forced to ack once its count reaches 8.

Source files
------------

// File: rtl/wt_dcache_rd_arb.sv
// ---------------------------------------------------------------------------
// wt_dcache_rd_arb
// Round-robin arbiter sharing the single read port of the write-through L1
// dcache arrays among NumPorts read controllers. The tag phase follows the
// grant by one cycle. The arbiter remembers the owner of that tag phase, so it
// can route the late tag to memory and mark who owns the returned hit/data.
//
// Optional feature: define WT_DCACHE_RD_ARB_STARVE_EN to add 4-bit per-port
// wait counters. A port that has waited 8 or more cycles overrides the
// round-robin choice. If several ports qualify, the lowest index wins.
// ---------------------------------------------------------------------------
module wt_dcache_rd_arb #(
    parameter int unsigned NumPorts = 3,
    parameter int unsigned IdxW     = 8,
    parameter int unsigned OffW     = 4,
    parameter int unsigned TagW     = 20
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic [NumPorts-1:0]      port_rd_req_i,
    input  logic [NumPorts-1:0]      port_rd_tag_only_i,
    input  logic [NumPorts*IdxW-1:0] port_rd_idx_i,
    input  logic [NumPorts*OffW-1:0] port_rd_off_i,
    input  logic [NumPorts*TagW-1:0] port_rd_tag_i,
    output logic [NumPorts-1:0]      port_rd_ack_o,
    output logic [NumPorts-1:0]      port_rd_vld_o,
    output logic                     mem_rd_req_o,
    output logic                     mem_rd_tag_only_o,
    output logic [IdxW-1:0]          mem_rd_idx_o,
    output logic [OffW-1:0]          mem_rd_off_o,
    output logic [TagW-1:0]          mem_rd_tag_o,
    input  logic                     mem_rd_ack_i,
    output logic                     busy_o
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0]     rr_ptr_d, rr_ptr_q;
    logic [NumPorts-1:0] tag_sel_d, tag_sel_q;
    logic                tag_vld_d, tag_vld_q;

    logic                rr_vld;
    logic [PtrW-1:0]     rr_idx;
    logic                win_vld;
    logic [PtrW-1:0]     win_idx;
    logic                grant;

    // Port index (base + ofs) wrapped modulo NumPorts.
    function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base,
                                                 input int unsigned     ofs);
        int unsigned sum;
        sum = 32'(base) + ofs;
        sum = sum % NumPorts;
        return sum[PtrW-1:0];
    endfunction

    // Round-robin pick: first requesting port at or after rr_ptr_q.
    always_comb begin
        logic [PtrW-1:0] cand;
        rr_vld = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = wrap_add(rr_ptr_q, i);
            if (!rr_vld && port_rd_req_i[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
    end

`ifdef WT_DCACHE_RD_ARB_STARVE_EN
    logic [3:0]      wait_cnt_d [NumPorts];
    logic [3:0]      wait_cnt_q [NumPorts];
    logic            starve_vld;
    logic [PtrW-1:0] starve_idx;

    // Lowest-index requester that has waited 8+ cycles overrides round-robin.
    always_comb begin
        starve_vld = 1'b0;
        starve_idx = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (!starve_vld && port_rd_req_i[i] && wait_cnt_q[i][3]) begin
                starve_vld = 1'b1;
                starve_idx = PtrW'(i);
            end
        end
        win_vld = rr_vld;
        win_idx = starve_vld ? starve_idx : rr_idx;
    end

    // Wait counters: count denied request cycles, clear on ack or flush, saturate.
    always_comb begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (clr_i || port_rd_ack_o[i]) begin
                wait_cnt_d[i] = 4'd0;
            end else if (port_rd_req_i[i] && wait_cnt_q[i] != 4'd15) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                wait_cnt_q[i] <= 4'd0;
            end
        end else begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end
`else
    // Pure round-robin: the round-robin pick is the winner.
    always_comb begin
        win_vld = rr_vld;
        win_idx = rr_idx;
    end
`endif

    assign grant        = win_vld & mem_rd_ack_i;
    assign mem_rd_req_o = |port_rd_req_i;

    // Request-phase mux toward memory and ack back to the winning port.
    always_comb begin
        port_rd_ack_o     = '0;
        mem_rd_tag_only_o = 1'b0;
        mem_rd_idx_o      = '0;
        mem_rd_off_o      = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (win_vld && (win_idx == PtrW'(i))) begin
                port_rd_ack_o[i]  = mem_rd_ack_i;
                mem_rd_tag_only_o = port_rd_tag_only_i[i];
                mem_rd_idx_o      = port_rd_idx_i[i*IdxW +: IdxW];
                mem_rd_off_o      = port_rd_off_i[i*OffW +: OffW];
            end
        end
    end

    // Tag-phase mux: late tag comes from the port granted last cycle.
    always_comb begin
        mem_rd_tag_o = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (tag_vld_q && tag_sel_q[i]) begin
                mem_rd_tag_o = mem_rd_tag_o | port_rd_tag_i[i*TagW +: TagW];
            end
        end
    end

    assign port_rd_vld_o = tag_vld_q ? tag_sel_q : '0;
    assign busy_o        = mem_rd_req_o | tag_vld_q;

    // Next state: a flush wins over a grant; a grant advances the pointer and opens the tag phase.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        tag_sel_d = tag_sel_q;
        tag_vld_d = 1'b0;
        if (clr_i) begin
            rr_ptr_d  = '0;
            tag_sel_d = '0;
        end else if (grant) begin
            rr_ptr_d  = wrap_add(win_idx, 1);
            tag_vld_d = 1'b1;
            for (int unsigned i = 0; i < NumPorts; i++) begin
                tag_sel_d[i] = (win_idx == PtrW'(i));
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            tag_sel_q <= '0;
            tag_vld_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            tag_sel_q <= tag_sel_d;
            tag_vld_q <= tag_vld_d;
        end
    end

    ack_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   $onehot0(port_rd_ack_o));
    tag_sel_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                       $onehot0(tag_sel_q));
    ack_needs_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     (port_rd_ack_o & ~port_rd_req_i) == '0);

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed testbench for wt_dcache_rd_arb (NumPorts=3, IdxW=6, OffW=4, TagW=8).
module tb_wt_dcache_rd_arb;

    localparam logic [17:0] IDX_DEF = {6'h33, 6'h22, 6'h11};
    localparam logic [11:0] OFF_DEF = {4'h3, 4'h2, 4'h1};
    localparam logic [23:0] TAG_DEF = {8'hC2, 8'hB1, 8'hA0};

    logic        clk_i;
    logic        rst_ni;
    logic        clr_i;
    logic [2:0]  port_rd_req_i;
    logic [2:0]  port_rd_tag_only_i;
    logic [17:0] port_rd_idx_i;
    logic [11:0] port_rd_off_i;
    logic [23:0] port_rd_tag_i;
    logic [2:0]  port_rd_ack_o;
    logic [2:0]  port_rd_vld_o;
    logic        mem_rd_req_o;
    logic        mem_rd_tag_only_o;
    logic [5:0]  mem_rd_idx_o;
    logic [3:0]  mem_rd_off_o;
    logic [7:0]  mem_rd_tag_o;
    logic        mem_rd_ack_i;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    int ackSeq [6] = '{1, 2, 4, 1, 2, 4};
    int vldSeq [6] = '{0, 1, 2, 4, 1, 2};
    int tagSeq [6] = '{0, 'hA0, 'hB1, 'hC2, 'hA0, 'hB1};
    int idxSeq [6] = '{'h11, 'h22, 'h33, 'h11, 'h22, 'h33};

    wt_dcache_rd_arb #(
        .NumPorts(3),
        .IdxW    (6),
        .OffW    (4),
        .TagW    (8)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .clr_i             (clr_i),
        .port_rd_req_i     (port_rd_req_i),
        .port_rd_tag_only_i(port_rd_tag_only_i),
        .port_rd_idx_i     (port_rd_idx_i),
        .port_rd_off_i     (port_rd_off_i),
        .port_rd_tag_i     (port_rd_tag_i),
        .port_rd_ack_o     (port_rd_ack_o),
        .port_rd_vld_o     (port_rd_vld_o),
        .mem_rd_req_o      (mem_rd_req_o),
        .mem_rd_tag_only_o (mem_rd_tag_only_o),
        .mem_rd_idx_o      (mem_rd_idx_o),
        .mem_rd_off_o      (mem_rd_off_o),
        .mem_rd_tag_o      (mem_rd_tag_o),
        .mem_rd_ack_i      (mem_rd_ack_i),
        .busy_o            (busy_o)
    );

    // Free-running clock, 10 time-unit period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Waits for the next rising edge, drives inputs at edge+1, and settles at edge+2 for sampling.
    task automatic applyStimulus(input logic [2:0] req, input logic [2:0] tagOnly,
                                 input logic memAck, input logic clr);
        @(posedge clk_i);
        #1;
        port_rd_req_i      = req;
        port_rd_tag_only_i = tagOnly;
        mem_rd_ack_i       = memAck;
        clr_i              = clr;
        #1;
    endtask

    // Compares one observed value against its expected value and counts the result.
    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // Directed sequence; the rr pointer value is tracked in the comments.
    initial begin
        rst_ni             = 1'b0;
        clr_i              = 1'b0;
        port_rd_req_i      = 3'b000;
        port_rd_tag_only_i = 3'b000;
        port_rd_idx_i      = IDX_DEF;
        port_rd_off_i      = OFF_DEF;
        port_rd_tag_i      = TAG_DEF;
        mem_rd_ack_i       = 1'b0;

        #12;
        $display("[TB] reset state");
        checkOutput("reset_busy", 32'(busy_o), 0);
        checkOutput("reset_vld", 32'(port_rd_vld_o), 0);
        checkOutput("reset_mem_req", 32'(mem_rd_req_o), 0);
        checkOutput("reset_tag", 32'(mem_rd_tag_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("[TB] all ports requesting, memory always accepts");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
            checkOutput("rr_ack", 32'(port_rd_ack_o), ackSeq[k]);
            checkOutput("rr_vld", 32'(port_rd_vld_o), vldSeq[k]);
            checkOutput("rr_tag", 32'(mem_rd_tag_o), tagSeq[k]);
            checkOutput("rr_idx", 32'(mem_rd_idx_o), idxSeq[k]);
        end
        // rr = 0
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0);
        checkOutput("tail_ack", 32'(port_rd_ack_o), 0);
        checkOutput("tail_vld", 32'(port_rd_vld_o), 4);
        checkOutput("tail_tag", 32'(mem_rd_tag_o), 'hC2);
        checkOutput("tail_busy", 32'(busy_o), 1);
        checkOutput("tail_mem_req", 32'(mem_rd_req_o), 0);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        checkOutput("idle_vld", 32'(port_rd_vld_o), 0);
        checkOutput("idle_busy", 32'(busy_o), 0);
        checkOutput("idle_tag", 32'(mem_rd_tag_o), 0);

        $display("[TB] port 1 stalled by memory for three cycles");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(3'b010, 3'b000, 1'b0, 1'b0);
            checkOutput("stall_ack", 32'(port_rd_ack_o), 0);
            checkOutput("stall_mem_req", 32'(mem_rd_req_o), 1);
            checkOutput("stall_idx", 32'(mem_rd_idx_o), 'h22);
            checkOutput("stall_vld", 32'(port_rd_vld_o), 0);
            checkOutput("stall_busy", 32'(busy_o), 1);
        end
        applyStimulus(3'b010, 3'b000, 1'b1, 1'b0);
        checkOutput("stall_grant_ack", 32'(port_rd_ack_o), 2);
        // rr = 2
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        checkOutput("stall_vld_after", 32'(port_rd_vld_o), 2);
        checkOutput("stall_tag_after", 32'(mem_rd_tag_o), 'hB1);

        $display("[TB] wrap from pointer 2 to port 0");
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b0);
        checkOutput("wrap_ack", 32'(port_rd_ack_o), 1);
        checkOutput("wrap_vld", 32'(port_rd_vld_o), 0);
        // rr = 1
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
        checkOutput("wrap_next_ack", 32'(port_rd_ack_o), 2);
        checkOutput("wrap_next_vld", 32'(port_rd_vld_o), 1);
        checkOutput("wrap_next_tag", 32'(mem_rd_tag_o), 'hA0);
        // rr = 2; a denied requester keeps priority
        applyStimulus(3'b111, 3'b000, 1'b0, 1'b0);
        checkOutput("deny_ack", 32'(port_rd_ack_o), 0);
        checkOutput("deny_idx", 32'(mem_rd_idx_o), 'h33);
        checkOutput("deny_vld", 32'(port_rd_vld_o), 2);
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
        checkOutput("deny_keep_ack", 32'(port_rd_ack_o), 4);
        checkOutput("deny_keep_vld", 32'(port_rd_vld_o), 0);

        $display("[TB] flush coincident with grant");
        // rr = 0
        applyStimulus(3'b100, 3'b000, 1'b1, 1'b1);
        checkOutput("clr_ack_driven", 32'(port_rd_ack_o), 4);
        checkOutput("clr_vld_prev", 32'(port_rd_vld_o), 4);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        checkOutput("clr_vld_killed", 32'(port_rd_vld_o), 0);
        checkOutput("clr_busy", 32'(busy_o), 0);
        checkOutput("clr_tag", 32'(mem_rd_tag_o), 0);
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b1);
        checkOutput("clr2_ack", 32'(port_rd_ack_o), 1);
        // A flush leaves rr at 0, so port 0 wins again.
        applyStimulus(3'b011, 3'b000, 1'b1, 1'b0);
        checkOutput("clr2_ptr_ack", 32'(port_rd_ack_o), 1);
        checkOutput("clr2_vld", 32'(port_rd_vld_o), 0);

        $display("[TB] tag-only lookup on port 2");
        // rr = 1
        port_rd_idx_i = {6'h3F, 6'h22, 6'h11};
        port_rd_off_i = {4'h8, 4'h2, 4'h1};
        applyStimulus(3'b100, 3'b100, 1'b1, 1'b0);
        checkOutput("tonly_ack", 32'(port_rd_ack_o), 4);
        checkOutput("tonly_idx", 32'(mem_rd_idx_o), 'h3F);
        checkOutput("tonly_off", 32'(mem_rd_off_o), 'h8);
        checkOutput("tonly_flag", 32'(mem_rd_tag_only_o), 1);
        checkOutput("tonly_vld_prev", 32'(port_rd_vld_o), 1);
        checkOutput("tonly_tag_prev", 32'(mem_rd_tag_o), 'hA0);
        applyStimulus(3'b000, 3'b100, 1'b0, 1'b0);
        checkOutput("tonly_tag", 32'(mem_rd_tag_o), 'hC2);
        checkOutput("tonly_vld", 32'(port_rd_vld_o), 4);
        checkOutput("tonly_idle_idx", 32'(mem_rd_idx_o), 0);
        checkOutput("tonly_idle_off", 32'(mem_rd_off_o), 0);
        checkOutput("tonly_idle_flag", 32'(mem_rd_tag_only_o), 0);
        checkOutput("tonly_busy", 32'(busy_o), 1);
        port_rd_idx_i      = IDX_DEF;
        port_rd_off_i      = OFF_DEF;
        port_rd_tag_only_i = 3'b000;

        $display("[TB] asynchronous reset during tag phase");
        // rr = 0
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
        checkOutput("arst_ack", 32'(port_rd_ack_o), 1);
        // rr = 1
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        checkOutput("arst_vld_before", 32'(port_rd_vld_o), 1);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_vld", 32'(port_rd_vld_o), 0);
        checkOutput("arst_busy", 32'(busy_o), 0);
        checkOutput("arst_tag", 32'(mem_rd_tag_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        // The reset returns rr to 0, so port 0 beats port 2.
        applyStimulus(3'b101, 3'b000, 1'b1, 1'b0);
        checkOutput("arst_ptr_ack", 32'(port_rd_ack_o), 1);
        checkOutput("arst_ptr_vld", 32'(port_rd_vld_o), 0);

        $display("[TB] long wait on port 0, then port 2 competes");
        // rr = 1; port 0 is denied for eight cycles
        for (int k = 0; k < 8; k++) begin
            applyStimulus(3'b001, 3'b000, 1'b0, 1'b0);
            checkOutput("wait_ack", 32'(port_rd_ack_o), 0);
        end
        applyStimulus(3'b101, 3'b000, 1'b1, 1'b0);
`ifdef WT_DCACHE_RD_ARB_STARVE_EN
        checkOutput("starve_ack", 32'(port_rd_ack_o), 1);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        checkOutput("starve_vld", 32'(port_rd_vld_o), 1);
`else
        checkOutput("starve_ack", 32'(port_rd_ack_o), 4);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        checkOutput("starve_vld", 32'(port_rd_vld_o), 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
